// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the sequence counter controller:
// control state encoding, state width and the power-up next-state table.
package seq_ctrl_pkg;

  localparam int CTRL_WIDTH = 4;
  localparam int CTRL_DEPTH = 2 ** CTRL_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } ctrl_state_t;

  typedef logic [CTRL_DEPTH-1:0][CTRL_WIDTH-1:0] seq_table_t;

  // Codes that belong to the default sequence 0,4,7,8,10,13,9,15.
  localparam logic [CTRL_DEPTH-1:0] DEFAULT_USED = 16'b1010_0111_1001_0001;

  // Index 15 first; entries for unused codes are ignored and resolved to the start state.
  localparam seq_table_t DEFAULT_TABLE = {
    4'd0, 4'd0, 4'd9,  4'd0,  4'd0,  4'd13, 4'd15, 4'd10,
    4'd8, 4'd0, 4'd0,  4'd7,  4'd0,  4'd0,  4'd0,  4'd4
  };

  function automatic logic [CTRL_WIDTH-1:0] default_entry(
    input logic [CTRL_WIDTH-1:0] idx,
    input logic [CTRL_WIDTH-1:0] start_state
  );
    logic [CTRL_WIDTH-1:0] val;
    if (DEFAULT_USED[idx]) begin
      val = DEFAULT_TABLE[idx];
    end else begin
      val = start_state;
    end
    return val;
  endfunction

endpackage

// File: rtl/seq_next_table.sv
// Next-state lookup table: one synchronous write port, one combinational
// read port, synchronously reloaded with the default sequence on clear.
module seq_next_table
  import seq_ctrl_pkg::*;
#(
  parameter logic [CTRL_WIDTH-1:0] START_STATE = 4'd0
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [CTRL_WIDTH-1:0] wr_addr,
  input  logic [CTRL_WIDTH-1:0] wr_data,
  input  logic [CTRL_WIDTH-1:0] rd_addr,
  output logic [CTRL_WIDTH-1:0] rd_data
);

  seq_table_t table_r;

  // Table storage: clear restores the default sequence, otherwise at most one write per edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < CTRL_DEPTH; i++) begin
        table_r[i] <= default_entry(CTRL_WIDTH'(i), START_STATE);
      end
    end else if (wr_en) begin
      table_r[wr_addr] <= wr_data;
    end
  end

  // Read sees pre-write contents, so an advance on the write edge uses the old entry.
  assign rd_data = table_r[rd_addr];

endmodule

// File: rtl/seq_counter_ctrl.sv
// Programmable-sequence counter controller: IDLE/RUN/PAUSE FSM, q register, wrap pulse.
// Optional wrap lap counter output laps[7:0] when SEQ_CTRL_LAP_CNT_EN is defined.
module seq_counter_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter logic [CTRL_WIDTH-1:0] START_STATE = 4'd0
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  step,
  input  logic                  rewind,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CTRL_WIDTH-1:0] cfg_addr,
  input  logic [CTRL_WIDTH-1:0] cfg_data,
  output logic [CTRL_WIDTH-1:0] q,
  output logic                  busy,
  output logic                  wrap
`ifdef SEQ_CTRL_LAP_CNT_EN
  ,
  output logic [7:0]            laps
`endif
);

  ctrl_state_t           state_r;
  ctrl_state_t           state_nx_s;
  logic [CTRL_WIDTH-1:0] q_r;
  logic [CTRL_WIDTH-1:0] q_nx_s;
  logic [CTRL_WIDTH-1:0] next_val_s;
  logic                  advance_s;
  logic                  wrap_r;
  logic                  wrap_nx_s;
  logic                  busy_r;
  logic                  cfg_ready_r;
  logic                  wr_en_s;

  assign wr_en_s = cfg_valid & cfg_ready_r;

  seq_next_table #(
    .START_STATE (START_STATE)
  ) u_table (
    .clk     (clk),
    .clear   (clear),
    .wr_en   (wr_en_s),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_addr (q_r),
    .rd_data (next_val_s)
  );

  // Control decode; rewind overrides every other control input but leaves the state alone.
  always_comb begin
    state_nx_s = state_r;
    q_nx_s     = q_r;
    advance_s  = 1'b0;
    if (rewind) begin
      q_nx_s = START_STATE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_nx_s = RUN;
          end else begin
            state_nx_s = IDLE;
          end
        end
        RUN: begin
          if (stop) begin
            state_nx_s = PAUSE;
          end else begin
            advance_s = 1'b1;
          end
        end
        PAUSE: begin
          if (start) begin
            state_nx_s = RUN;
          end else if (step) begin
            advance_s = 1'b1;
          end else begin
            state_nx_s = PAUSE;
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
      if (advance_s) begin
        q_nx_s = next_val_s;
      end else begin
        q_nx_s = q_r;
      end
    end
    wrap_nx_s = advance_s && (next_val_s == START_STATE);
  end

  // State, count and registered status outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r     <= IDLE;
      q_r         <= START_STATE;
      wrap_r      <= 1'b0;
      busy_r      <= 1'b0;
      cfg_ready_r <= 1'b1;
    end else begin
      state_r     <= state_nx_s;
      q_r         <= q_nx_s;
      wrap_r      <= wrap_nx_s;
      busy_r      <= (state_nx_s == RUN);
      cfg_ready_r <= (state_nx_s != RUN);
    end
  end

  assign q         = q_r;
  assign busy      = busy_r;
  assign wrap      = wrap_r;
  assign cfg_ready = cfg_ready_r;

`ifdef SEQ_CTRL_LAP_CNT_EN
  logic [7:0] laps_r;

  // Saturating count of wrap pulses, updated on the same edge that raises wrap.
  always_ff @(posedge clk) begin
    if (clear || rewind) begin
      laps_r <= 8'd0;
    end else if (wrap_nx_s && (laps_r != 8'd255)) begin
      laps_r <= laps_r + 8'd1;
    end
  end

  assign laps = laps_r;
`endif

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Directed self-checking bench for seq_counter_ctrl; lap counter checks
// are included when SEQ_CTRL_LAP_CNT_EN is defined.
module tb_seq_counter_ctrl;

  logic       clk;
  logic       clear;
  logic       start;
  logic       stop;
  logic       step;
  logic       rewind;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_addr;
  logic [3:0] cfg_data;
  logic [3:0] q;
  logic       busy;
  logic       wrap;
`ifdef SEQ_CTRL_LAP_CNT_EN
  logic [7:0] laps;
`endif

  int n_checks;
  int n_fail;

  seq_counter_ctrl dut (
    .clk       (clk),
    .clear     (clear),
    .start     (start),
    .stop      (stop),
    .step      (step),
    .rewind    (rewind),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .q         (q),
    .busy      (busy),
    .wrap      (wrap)
`ifdef SEQ_CTRL_LAP_CNT_EN
    ,
    .laps      (laps)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation still running at %0t, limit 1000000", $time);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    clear = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; rewind = 1'b0;
    cfg_valid = 1'b0; cfg_addr = 4'd0; cfg_data = 4'd0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    start = 1'b1; step = 1'b1;
    do_clear();
    start = 1'b0; step = 1'b0;
    n_checks++; if (q !== 4'd0) begin n_fail++; $display("FAIL reset_q: got %0d expected 0", q); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
`ifdef SEQ_CTRL_LAP_CNT_EN
    n_checks++; if (laps !== 8'd0) begin n_fail++; $display("FAIL reset_laps: got %0d expected 0", laps); end
`endif
  endtask

  task automatic test_run();
    logic [3:0] seq_e [0:8];
    logic       wrap_e;
    seq_e = '{4'd0, 4'd4, 4'd7, 4'd8, 4'd10, 4'd13, 4'd9, 4'd15, 4'd0};
    do_clear();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      wrap_e = (i == 8) ? 1'b1 : 1'b0;
      n_checks++; if (q !== seq_e[i]) begin n_fail++; $display("FAIL run_q[%0d]: got %0d expected %0d", i, q, seq_e[i]); end
      n_checks++; if (wrap !== wrap_e) begin n_fail++; $display("FAIL run_wrap[%0d]: got %b expected %b", i, wrap, wrap_e); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL run_busy[%0d]: got %b expected 1", i, busy); end
    end
    stop = 1'b1; tick(); stop = 1'b0;
    n_checks++; if (q !== 4'd0) begin n_fail++; $display("FAIL run_stop_q: got %0d expected 0", q); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL run_stop_wrap: got %b expected 0", wrap); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL run_stop_busy: got %b expected 0", busy); end
  endtask

  task automatic test_pause_step();
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL pause_cfg_ready_run: got %b expected 0", cfg_ready); end
    tick(); tick();
    n_checks++; if (q !== 4'd7) begin n_fail++; $display("FAIL pause_pre_q: got %0d expected 7", q); end
    stop = 1'b1; tick(); stop = 1'b0;
    n_checks++; if (q !== 4'd7) begin n_fail++; $display("FAIL pause_stop_q: got %0d expected 7", q); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pause_busy: got %b expected 0", busy); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL pause_cfg_ready: got %b expected 1", cfg_ready); end
    tick();
    n_checks++; if (q !== 4'd7) begin n_fail++; $display("FAIL pause_hold_q: got %0d expected 7", q); end
    step = 1'b1; tick(); step = 1'b0;
    n_checks++; if (q !== 4'd8) begin n_fail++; $display("FAIL step1_q: got %0d expected 8", q); end
    step = 1'b1; tick(); step = 1'b0;
    n_checks++; if (q !== 4'd10) begin n_fail++; $display("FAIL step2_q: got %0d expected 10", q); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL step2_busy: got %b expected 0", busy); end
  endtask

  task automatic test_cfg_write();
    do_clear();
    cfg_valid = 1'b1; cfg_addr = 4'd3; cfg_data = 4'd5; tick();
    cfg_addr = 4'd0; cfg_data = 4'd3; tick();
    cfg_valid = 1'b0;
    rewind = 1'b1; tick(); rewind = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (q !== 4'd0) begin n_fail++; $display("FAIL cfg_start_q: got %0d expected 0", q); end
    tick();
    n_checks++; if (q !== 4'd3) begin n_fail++; $display("FAIL cfg_q1: got %0d expected 3", q); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL cfg_wrap1: got %b expected 0", wrap); end
    tick();
    n_checks++; if (q !== 4'd5) begin n_fail++; $display("FAIL cfg_q2: got %0d expected 5", q); end
    tick();
    n_checks++; if (q !== 4'd0) begin n_fail++; $display("FAIL cfg_q3: got %0d expected 0", q); end
    n_checks++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL cfg_wrap3: got %b expected 1", wrap); end
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_cfg_stall();
    do_clear();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    n_checks++; if (q !== 4'd4) begin n_fail++; $display("FAIL stall_pre_q: got %0d expected 4", q); end
    // Request held from here on while RUN keeps advancing.
    cfg_valid = 1'b1; cfg_addr = 4'd4; cfg_data = 4'd1;
    tick();
    n_checks++; if (q !== 4'd7) begin n_fail++; $display("FAIL stall_q_a: got %0d expected 7", q); end
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL stall_cfg_ready: got %b expected 0", cfg_ready); end
    rewind = 1'b1; tick(); rewind = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_rewind_busy: got %b expected 1", busy); end
    tick(); tick();
    n_checks++; if (q !== 4'd7) begin n_fail++; $display("FAIL stall_q_b: got %0d expected 7", q); end
    rewind = 1'b1; tick(); rewind = 1'b0;
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    n_checks++; if (q !== 4'd4) begin n_fail++; $display("FAIL stall_stop_q: got %0d expected 4", q); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL stall_pause_ready: got %b expected 1", cfg_ready); end
    tick();
    cfg_valid = 1'b0;
    n_checks++; if (q !== 4'd4) begin n_fail++; $display("FAIL stall_accept_q: got %0d expected 4", q); end
    step = 1'b1; tick(); step = 1'b0;
    n_checks++; if (q !== 4'd1) begin n_fail++; $display("FAIL stall_step_q: got %0d expected 1", q); end
  endtask

  task automatic test_priority();
    do_clear();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (q !== 4'd13) begin n_fail++; $display("FAIL prio_pre_q: got %0d expected 13", q); end
    stop = 1'b1; start = 1'b1; step = 1'b1; tick();
    stop = 1'b0; start = 1'b0; step = 1'b0;
    n_checks++; if (q !== 4'd13) begin n_fail++; $display("FAIL prio_sss_q: got %0d expected 13", q); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_sss_busy: got %b expected 0", busy); end
    rewind = 1'b1; step = 1'b1; tick();
    rewind = 1'b0; step = 1'b0;
    n_checks++; if (q !== 4'd0) begin n_fail++; $display("FAIL prio_rewind_q: got %0d expected 0", q); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL prio_rewind_wrap: got %b expected 0", wrap); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_rewind_busy: got %b expected 0", busy); end
    step = 1'b1; tick(); step = 1'b0;
    n_checks++; if (q !== 4'd4) begin n_fail++; $display("FAIL prio_step_q: got %0d expected 4", q); end
  endtask

  task automatic test_clear_mid_run();
    do_clear();
    cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = 4'd2; tick();
    cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    n_checks++; if (q !== 4'd2) begin n_fail++; $display("FAIL clr_q_over: got %0d expected 2", q); end
    tick();
    n_checks++; if (q !== 4'd0) begin n_fail++; $display("FAIL clr_unused_q: got %0d expected 0", q); end
    n_checks++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL clr_unused_wrap: got %b expected 1", wrap); end
    clear = 1'b1; tick(); clear = 1'b0;
    n_checks++; if (q !== 4'd0) begin n_fail++; $display("FAIL clr_q: got %0d expected 0", q); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %b expected 0", busy); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL clr_wrap: got %b expected 0", wrap); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL clr_cfg_ready: got %b expected 1", cfg_ready); end
    // A write presented on the clear edge must be discarded.
    clear = 1'b1; cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = 4'd6; tick();
    clear = 1'b0; cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    n_checks++; if (q !== 4'd4) begin n_fail++; $display("FAIL clr_default_q: got %0d expected 4", q); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clr_default_busy: got %b expected 1", busy); end
  endtask

`ifdef SEQ_CTRL_LAP_CNT_EN
  task automatic test_laps();
    do_clear();
    cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = 4'd0; tick();
    cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (laps !== 8'd0) begin n_fail++; $display("FAIL laps_start: got %0d expected 0", laps); end
    tick();
    n_checks++; if (laps !== 8'd1) begin n_fail++; $display("FAIL laps_one: got %0d expected 1", laps); end
    for (int i = 0; i < 299; i++) tick();
    n_checks++; if (laps !== 8'd255) begin n_fail++; $display("FAIL laps_sat: got %0d expected 255", laps); end
    rewind = 1'b1; tick(); rewind = 1'b0;
    n_checks++; if (laps !== 8'd0) begin n_fail++; $display("FAIL laps_rewind: got %0d expected 0", laps); end
    stop = 1'b1; tick(); stop = 1'b0;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    drive_idle();
    tick();
    test_reset();
    test_run();
    test_pause_step();
    test_cfg_write();
    test_cfg_stall();
    test_priority();
    test_clear_mid_run();
`ifdef SEQ_CTRL_LAP_CNT_EN
    test_laps();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
